vga_timing_gen: RTL

Parametrised VGA timing generator for the vgaTT Tiny Tapeout design. It produces the horizontal and vertical sync, the active-video flag, pixel coordinates and line/frame strobes from a single pixel clock. Every pixel-generation block in `tt_um_matth_fischer_vgaTT` consumes these signals. This block generalises the fixed 640x480@60 timing to arbitrary porch, sync and active lengths, programmable sync polarity, a clock-enable, and an optional frame counter.

---
 rtl/vga_timing_gen.sv | 75 +++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync, coordinate and strobe generator driven by the pixel clock.
// Optional frame counter built only when VGATT_FRAME_CNT_EN is defined; otherwise frame_cnt is tied to 0.
module vga_timing_gen #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int CW        = 10,
   parameter int FC_W      = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   output logic            hsync,
   output logic            vsync,
   output logic            display_on,
   output logic [CW-1:0]   hpos,
   output logic [CW-1:0]   vpos,
   output logic            line_start,
   output logic            frame_start,
   output logic [FC_W-1:0] frame_cnt
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] V_SS   = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] V_SE   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
   logic          h_wrap, v_wrap;
   logic [CW-1:0] h_nxt, v_nxt;
   always_comb begin
      h_wrap = hpos == H_LAST;
      v_wrap = vpos == V_LAST;
      h_nxt  = h_wrap ? '0 : hpos + 1'b1;
      v_nxt  = !h_wrap ? vpos : v_wrap ? '0 : vpos + 1'b1;
   end
   // decoded from the next counter values so sync and display_on carry no skew against hpos/vpos
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         hpos        <= H_LAST;
         vpos        <= V_LAST;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         display_on  <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= ena && h_wrap;
         frame_start <= ena && h_wrap && v_wrap;
         if (ena) begin
            hpos       <= h_nxt;
            vpos       <= v_nxt;
            hsync      <= (h_nxt >= H_SS && h_nxt <= H_SE) ? HSYNC_POL : ~HSYNC_POL;
            vsync      <= (v_nxt >= V_SS && v_nxt <= V_SE) ? VSYNC_POL : ~VSYNC_POL;
            display_on <= h_nxt < H_ACT && v_nxt < V_ACT;
         end
      end
`ifdef VGATT_FRAME_CNT_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) frame_cnt <= '0;
      else if (ena && h_wrap && v_wrap) frame_cnt <= frame_cnt + 1'b1;
`else
   assign frame_cnt = '0;
`endif
endmodule
